// File: rtl/dmem_unit.sv
// dmem_unit: byte-addressed data memory for the core's memory stage.
// Byte/halfword/word loads and stores with sign/zero extension, alignment and
// range faults, a configurable wait-state delay and valid/ready handshakes on
// both the request and the response side.
// Optional build macro: DMEM_PERF_CNT_EN adds saturating load/store/fault
// counters on the cnt_load, cnt_store and cnt_fault outputs.
module dmem_unit #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0]       cnt_load,
  output logic [15:0]       cnt_store,
  output logic [15:0]       cnt_fault
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               we_q;
  logic [1:0]         size_q;
  logic               signed_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_word;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   rd_idx;
  logic [1:0]         lane;
  logic               accept;
  logic               out_of_range;
  logic               fault;
  logic               mem_we;
  logic [3:0]         be;
  logic [31:0]        wr_lanes;
  logic [31:0]        shifted;
  logic [31:0]        load_val;

  assign accept = req_valid && req_ready;
  assign idx_q  = addr_q[IDX_W+1:2];
  assign lane   = addr_q[1:0];
  assign mem_we = (state == ACCESS) && we_q && !fault;

  // The RAM read port is registered, so the word has to be addressed one
  // cycle before ACCESS; with no wait states that cycle is the accept cycle
  // itself, when only the live request address is available.
  assign rd_idx = (state == IDLE) ? req_addr[IDX_W+1:2] : idx_q;

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign out_of_range = |addr_q[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Decode the latched request: fault, byte enables, lane-replicated store
  // data and the extended load value taken from the addressed lanes.
  always_comb begin
    fault    = out_of_range;
    be       = 4'b0000;
    wr_lanes = wdata_q;
    shifted  = rd_word >> {lane, 3'b000};
    load_val = rd_word;
    case (size_q)
      2'b00: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{wdata_q[7:0]}};
        load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        fault    = out_of_range | lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
        load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        fault = out_of_range | (lane != 2'b00);
        be    = 4'b1111;
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

  // Block RAM with per-byte write enables and a registered read port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) begin
        mem[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
    rd_word <= mem[rd_idx];
  end

  // Request/response sequencer: accept, wait out the wait states, access the
  // array once, then hold the response until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            we_q      <= req_we;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= CNT_INIT;
            req_ready <= 1'b0;
            state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          rsp_fault <= fault;
          rsp_rdata <= (fault || we_q) ? 32'd0 : load_val;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_fault <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Count each access by outcome; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_load  <= 16'd0;
      cnt_store <= 16'd0;
      cnt_fault <= 16'd0;
    end else if (state == ACCESS) begin
      if (fault) begin
        if (cnt_fault != 16'hFFFF) cnt_fault <= cnt_fault + 16'd1;
      end else if (we_q) begin
        if (cnt_store != 16'hFFFF) cnt_store <= cnt_store + 16'd1;
      end else begin
        if (cnt_load != 16'hFFFF) cnt_load <= cnt_load + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: self-checking bench for dmem_unit. Instance A uses one wait
// state and is compared against a byte-array model; instance B uses four wait
// states for the reset-during-wait sequence.
module tb_dmem_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_ready_a, req_ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic        rsp_fault_a, rsp_fault_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
`ifdef DMEM_PERF_CNT_EN
  logic [15:0] cnt_load_a, cnt_store_a, cnt_fault_a;
  logic [15:0] cnt_load_b, cnt_store_b, cnt_fault_b;
`endif

  always #5 clk = ~clk;

  dmem_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_fault(rsp_fault_a)
`ifdef DMEM_PERF_CNT_EN
    , .cnt_load(cnt_load_a), .cnt_store(cnt_store_a), .cnt_fault(cnt_fault_a)
`endif
  );

  dmem_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_fault(rsp_fault_b)
`ifdef DMEM_PERF_CNT_EN
    , .cnt_load(cnt_load_b), .cnt_store(cnt_store_b), .cnt_fault(cnt_fault_b)
`endif
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: memory as individual bytes, outcome counters.
  logic [7:0] mMem [bit [31:0]];
  int mLoad = 0;
  int mStore = 0;
  int mFault = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expFault;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got timeout, expected handshake", name);
  endtask

  // Applies the memory rules to the byte array and predicts the response.
  task automatic modelOp(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic fault);
    int n;
    logic [31:0] val;
    n = 1 << size;
    rdata = 32'd0;
    fault = (size == 2'b11) || ((addr % n) != 0) || ((addr >> 2) >= DEPTH);
    if (fault) begin
      if (mFault < 65535) mFault++;
    end else if (we) begin
      for (int i = 0; i < n; i++) mMem[addr + i] = wdata[8*i +: 8];
      if (mStore < 65535) mStore++;
    end else begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = mMem[addr + i];
      if (sgn && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      rdata = val;
      if (mLoad < 65535) mLoad++;
    end
  endtask

  function automatic logic readyOf(input bit sel);
    return sel ? req_ready_b : req_ready_a;
  endfunction

  function automatic logic validOf(input bit sel);
    return sel ? rsp_valid_b : rsp_valid_a;
  endfunction

  function automatic logic [31:0] rdataOf(input bit sel);
    return sel ? rsp_rdata_b : rsp_rdata_a;
  endfunction

  function automatic logic faultOf(input bit sel);
    return sel ? rsp_fault_b : rsp_fault_a;
  endfunction

  task automatic setValid(input bit sel, input logic v);
    if (sel) req_valid_b = v;
    else req_valid_a = v;
  endtask

  // Drive a request and return at the falling edge after the accept edge.
  task automatic startReq(input bit sel, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    guard = 0;
    @(negedge clk);
    req_we = we;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    setValid(sel, 1'b1);
    while (!readyOf(sel) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) reportTimeout("accept");
    @(posedge clk);
    @(negedge clk);
    setValid(sel, 1'b0);
  endtask

  // Latency counts rising edges from the accept edge (inclusive) to rsp_valid.
  task automatic waitRsp(input bit sel, output int lat);
    lat = 1;
    while (!validOf(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) reportTimeout("response");
  endtask

  task automatic finishRsp(input bit sel, input string name);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({name, " req_ready after handshake"}, {31'd0, readyOf(sel)}, 32'd1);
    checkOutput({name, " rsp_valid after handshake"}, {31'd0, validOf(sel)}, 32'd0);
  endtask

  task automatic applyStimulus(input bit sel, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input string name, output logic [31:0] rdata,
                               output logic fault, output int lat);
    startReq(sel, we, size, sgn, addr, wdata);
    waitRsp(sel, lat);
    rdata = rdataOf(sel);
    fault = faultOf(sel);
    finishRsp(sel, name);
  endtask

  // Global bound so the run always terminates.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, expRd;
    logic        flt, expFlt;
    int          lat;
    logic        seen;
    logic [1:0]  sz;
    logic [31:0] ad;
    int          r;

    // Reset values while reset is held.
    rst = 1'b0;
    #3;
    checkOutput("reset req_ready", {31'd0, req_ready_a}, 32'd0);
    checkOutput("reset rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata_a, 32'd0);
    checkOutput("reset rsp_fault", {31'd0, rsp_fault_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors: {we, size, signed, addr, wdata, expected data, expected fault}.
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h40,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h80,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h81,  32'h000000AA, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h80,  32'h0,        32'h1122AA44, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h81,  32'h0,        32'hFFFFFFAA, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h81,  32'h0,        32'h000000AA, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h82,  32'h0,        32'h00001122, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h42,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h43,  32'h0000BBBB, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h40,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h86,  32'h12348001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h86,  32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h86,  32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h87,  32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'hFFFFFFF0, 32'h0,   32'h0,        1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    $sformatf("vec%0d", i), rd, flt, lat);
      checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expData);
      checkOutput($sformatf("vec%0d fault", i), {31'd0, flt}, {31'd0, vecs[i].expFault});
      checkOutput($sformatf("vec%0d latency", i), lat, 32'd3);
      modelOp(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, expRd, expFlt);
    end

    // Backpressure: response held five cycles, a request driven meanwhile is ignored.
    startReq(1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    waitRsp(1'b0, lat);
    modelOp(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, expRd, expFlt);
    req_we = 1'b1;
    req_wdata = 32'h0;
    req_valid_a = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d rsp_valid", c), {31'd0, rsp_valid_a}, 32'd1);
      checkOutput($sformatf("bp%0d rsp_rdata", c), rsp_rdata_a, 32'h1122AA44);
      checkOutput($sformatf("bp%0d rsp_fault", c), {31'd0, rsp_fault_a}, 32'd0);
      checkOutput($sformatf("bp%0d req_ready", c), {31'd0, req_ready_a}, 32'd0);
    end
    req_valid_a = 1'b0;
    finishRsp(1'b0, "bp");
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, "bp reload", rd, flt, lat);
    modelOp(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, expRd, expFlt);
    checkOutput("bp reload rdata", rd, 32'h1122AA44);

    // Reset during the second wait cycle of a byte store on the four-wait instance.
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D, "rst prep", rd, flt, lat);
    checkOutput("rst prep fault", {31'd0, flt}, 32'd0);
    checkOutput("rst prep latency", lat, 32'd6);
    startReq(1'b1, 1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset req_ready idle unit", {31'd0, req_ready_a}, 32'd0);
    checkOutput("async reset req_ready", {31'd0, req_ready_b}, 32'd0);
    checkOutput("async reset rsp_valid", {31'd0, rsp_valid_b}, 32'd0);
    checkOutput("async reset rsp_rdata", rsp_rdata_b, 32'd0);
    checkOutput("async reset rsp_fault", {31'd0, rsp_fault_b}, 32'd0);
    mLoad = 0;
    mStore = 0;
    mFault = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid_b) seen = 1'b1;
    end
    checkOutput("no stray rsp_valid", {31'd0, seen}, 32'd0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "rst reload", rd, flt, lat);
    checkOutput("rst reload rdata", rd, 32'hCAFEF00D);

    // Mixed sequence after reset: two stores, three loads, one misaligned load.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, "mix st0", rd, flt, lat);
    modelOp(1'b1, 2'b10, 1'b0, 32'h20, 32'h01020304, expRd, expFlt);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h24, 32'h000000F5, "mix st1", rd, flt, lat);
    modelOp(1'b1, 2'b00, 1'b0, 32'h24, 32'h000000F5, expRd, expFlt);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "mix ld0", rd, flt, lat);
    checkOutput("mix ld0 rdata", rd, 32'h01020304);
    modelOp(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, expRd, expFlt);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h24, 32'h0, "mix ld1", rd, flt, lat);
    checkOutput("mix ld1 rdata", rd, 32'hFFFFFFF5);
    modelOp(1'b0, 2'b00, 1'b1, 32'h24, 32'h0, expRd, expFlt);
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, "mix ld2", rd, flt, lat);
    checkOutput("mix ld2 rdata", rd, 32'h00000102);
    modelOp(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, expRd, expFlt);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, "mix ld3", rd, flt, lat);
    checkOutput("mix ld3 fault", {31'd0, flt}, 32'd1);
    modelOp(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, expRd, expFlt);
`ifdef DMEM_PERF_CNT_EN
    checkOutput("cnt_load", {16'd0, cnt_load_a}, 32'd3);
    checkOutput("cnt_store", {16'd0, cnt_store_a}, 32'd2);
    checkOutput("cnt_fault", {16'd0, cnt_fault_a}, 32'd1);
`endif

    // Random phase: fill a 256-byte window, then mixed random accesses.
    for (int w = 0; w < 64; w++) begin
      r = $urandom;
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), 32'(r), "fill", rd, flt, lat);
      modelOp(1'b1, 2'b10, 1'b0, 32'(w * 4), 32'(r), expRd, expFlt);
      checkOutput($sformatf("fill%0d fault", w), {31'd0, flt}, {31'd0, expFlt});
    end
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      ad = ($urandom_range(0, 15) == 0) ? 32'(32'h1000 + $urandom_range(0, 255))
                                        : 32'($urandom_range(0, 255));
      req_signed = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      r = $urandom;
      begin
        logic weR, sgR;
        weR = req_we;
        sgR = req_signed;
        modelOp(weR, sz, sgR, ad, 32'(r), expRd, expFlt);
        applyStimulus(1'b0, weR, sz, sgR, ad, 32'(r), "rand", rd, flt, lat);
      end
      checkOutput($sformatf("rand%0d rdata @%0h", k, ad), rd, expRd);
      checkOutput($sformatf("rand%0d fault @%0h", k, ad), {31'd0, flt}, {31'd0, expFlt});
      checkOutput($sformatf("rand%0d latency", k), lat, 32'd3);
    end
`ifdef DMEM_PERF_CNT_EN
    checkOutput("final cnt_load", {16'd0, cnt_load_a}, 32'(mLoad));
    checkOutput("final cnt_store", {16'd0, cnt_store_a}, 32'(mStore));
    checkOutput("final cnt_fault", {16'd0, cnt_fault_a}, 32'(mFault));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
Name: dmem_unit

Overview:
- Parametrised, byte-addressed data memory for the ARM core's memory stage; successor to the single-cycle word-only data memory.
- Adds byte/halfword/word access with sign/zero extension and alignment and range faults.
- Adds a configurable wait-state counter and a valid/ready request/response handshake, so the pipeline can stall on slow memory.

Parameters:
- ADDR_W, 32, request byte-address width.
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 1, extra cycles between request accept and response; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_signed  input  1  load sign-extends when 1; ignored for word access and for stores.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load data, extended; 0 for stores and faults.
- rsp_fault  output  1  request was misaligned, out of range or of reserved size.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Memory array is not cleared.
- req_ready is 1 only in IDLE with rst=1. It is not combinationally dependent on req_valid.
- FSM states:
  - IDLE: on req_valid&&req_ready, latch we/size/signed/addr/wdata. Go to WAIT with cnt=WAIT_CYCLES-1, or directly to ACCESS if WAIT_CYCLES=0.
  - WAIT: cnt decrements each cycle; at cnt==0 go to ACCESS.
  - ACCESS: one cycle. Evaluate the fault; commit the store or sample the load; register rsp_rdata/rsp_fault; go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_fault are held stable until rsp_valid&&rsp_ready; then go to IDLE.
- Latency: accept edge to rsp_valid high is WAIT_CYCLES+2 clocks. The next accept is possible the cycle after the response handshake.
- Fault conditions (OR of):
  - size==11.
  - size==01 and addr[0]!=0.
  - size==10 and addr[1:0]!=0.
  - addr[ADDR_W-1:2] >= DEPTH.
- On fault: no memory write, rsp_rdata=0, rsp_fault=1.
- Word index is addr[log2(DEPTH)+1:2]. Lane is addr[1:0].
- Store:
  - Byte writes only lane addr[1:0] with wdata[7:0].
  - Halfword writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word writes all four lanes.
  - Unwritten lanes keep their contents.
  - Store response: rsp_rdata=0, rsp_fault=0.
- Load:
  - Extract the addressed byte or halfword, little-endian.
  - Zero-extend when req_signed=0; replicate the MSB when req_signed=1.
  - Word loads are returned unchanged.
- Load immediately after a store to the same address returns the new data. The store is committed in ACCESS before the later request is accepted.
- Inputs are ignored outside the IDLE accept cycle. Changes to req_* while not ready have no effect.
- Reset mid-operation:
  - In WAIT, the request is dropped and memory is unchanged.
  - In RESP, the store is already committed and the response is lost.
  - No response is generated after reset release.
- Memory is a synchronous-write, synchronous-read array, inferable as block RAM with byte enables.

Optional Feature:
- Macro DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs cnt_load[15:0], cnt_store[15:0] and cnt_fault[15:0].
  - Each counter increments by 1 in ACCESS for a non-faulting load, a non-faulting store, or any fault respectively.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Word round trip, WAIT_CYCLES=1: store 0xDEADBEEF to addr 0x40, then load word 0x40.
  - Expect rsp_rdata=0xDEADBEEF, rsp_fault=0.
  - Expect rsp_valid 3 clocks after each accept.
- Byte/halfword lanes: word store 0x11223344 at 0x80, then byte store 0xAA at 0x81.
  - Word load at 0x80 gives 0x1122AA44.
  - Signed byte load at 0x81 gives 0xFFFFFFAA; unsigned gives 0x000000AA.
  - Signed halfword load at 0x82 gives 0x00001122.
- Faults: word load at 0x42 -> rsp_fault=1, rdata=0.
  - Halfword store at 0x43 -> fault, and memory is unchanged (verify by reload).
  - Load at DEPTH*4 -> fault.
  - size=11 -> fault.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_fault stay stable; req_ready=0 throughout.
  - With rsp_ready=1, the handshake completes and req_ready=1 the next cycle.
- Reset mid-op: accept a store of 0x55 to 0x10 with WAIT_CYCLES=4; assert rst in the 2nd WAIT cycle.
  - Outputs go to 0 asynchronously.
  - A later load of 0x10 returns the old value.
  - No stray rsp_valid appears.
- DMEM_PERF_CNT_EN: issue 3 loads, 2 stores and 1 misaligned load.
  - Expect cnt_load=3, cnt_store=2, cnt_fault=1.
  - Preload cnt_fault near 16'hFFFF via repeated faults and check it saturates.
